// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - run/pause/single-step timebase tick controller
//
// Purpose: owns the timebase divide counter and emits a one-cycle clock-enable
// pulse (tick) at one of four selectable divide ratios. Rate changes requested
// while running are held until the next period boundary, so no period is cut short.
//
// Ports:
//   clk_in     in   system clock
//   rst_n      in   asynchronous active-low reset
//   run        in   level, 1 = free-run, 0 = stopped
//   step       in   pulse, request one tick while stopped
//   rate_sel   in   divide-ratio index
//   rate_load  in   pulse, latch rate_sel
//   tick       out  one-cycle enable pulse (registered)
//   running    out  1 while in RUN (registered)
//   rate_cur   out  index of the divisor currently in effect
//   rate_pend  out  1 while a queued rate change awaits a boundary

module tick_ctrl #(
  parameter int DIV0 = 25000000,
  parameter int DIV1 = 12500000,
  parameter int DIV2 = 5000000,
  parameter int DIV3 = 1,
  parameter int CW   = 25
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic [1:0] rate_sel,
  input  logic       rate_load,
  output logic       tick,
  output logic       running,
  output logic [1:0] rate_cur,
  output logic       rate_pend
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] last_cnt;
  logic          terminal;
  logic          tick_n, running_n, rate_pend_n;
  logic [1:0]    rate_cur_n, pend_idx, pend_idx_n;

  // Terminal count of the divisor in effect (div_cur - 1).
  always_comb begin
    case (rate_cur)
      2'd0: last_cnt = CW'(DIV0 - 1);
      2'd1: last_cnt = CW'(DIV1 - 1);
      2'd2: last_cnt = CW'(DIV2 - 1);
      2'd3: last_cnt = CW'(DIV3 - 1);
    endcase
  end

  assign terminal = (cnt == last_cnt);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tick_n      = 1'b0;
    rate_cur_n  = rate_cur;
    rate_pend_n = rate_pend;
    pend_idx_n  = pend_idx;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (rate_load) rate_cur_n = rate_sel;
        // run has priority over step
        if (run)       state_n = S_RUN;
        else if (step) state_n = S_STEP;
      end
      S_STEP: begin
        tick_n  = 1'b1;
        state_n = S_IDLE;
        if (rate_load) rate_cur_n = rate_sel;
      end
      S_RUN: begin
        if (!run) begin
          // Leaving RUN: no tick on the exit edge, and any queued rate is
          // applied now (a load on this same edge is the latest request).
          state_n     = S_IDLE;
          cnt_n       = '0;
          rate_pend_n = 1'b0;
          if (rate_load)      rate_cur_n = rate_sel;
          else if (rate_pend) rate_cur_n = pend_idx;
        end else begin
          if (terminal) begin
            cnt_n  = '0;
            tick_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
          // A load always lands in the pending slot, even on a terminal edge,
          // so it takes effect at the following boundary.
          if (rate_load) begin
            pend_idx_n  = rate_sel;
            rate_pend_n = 1'b1;
          end else if (terminal && rate_pend) begin
            rate_cur_n  = pend_idx;
            rate_pend_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign running_n = (state_n == S_RUN);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tick      <= 1'b0;
      running   <= 1'b0;
      rate_cur  <= 2'd0;
      rate_pend <= 1'b0;
      pend_idx  <= 2'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tick      <= tick_n;
      running   <= running_n;
      rate_cur  <= rate_cur_n;
      rate_pend <= rate_pend_n;
      pend_idx  <= pend_idx_n;
    end
  end

endmodule

// File: tb/tb_tick_ctrl.sv
// tb/tb_tick_ctrl.sv - self-checking bench for tick_ctrl
//
// Purpose: drives directed and random run/step/rate_load sequences into
// tick_ctrl (small divisors 4/6/2/1) and compares every output with a
// behavioural model of the timebase.

module tb_tick_ctrl;

  logic       clk_in    = 1'b0;
  logic       rst_n     = 1'b0;
  logic       run       = 1'b0;
  logic       step      = 1'b0;
  logic [1:0] rate_sel  = 2'd0;
  logic       rate_load = 1'b0;
  logic       tick;
  logic       running;
  logic [1:0] rate_cur;
  logic       rate_pend;

  int n_checks = 0;
  int n_pass   = 0;

  tick_ctrl #(
    .DIV0(4),
    .DIV1(6),
    .DIV2(2),
    .DIV3(1),
    .CW  (25)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .run      (run),
    .step     (step),
    .rate_sel (rate_sel),
    .rate_load(rate_load),
    .tick     (tick),
    .running  (running),
    .rate_cur (rate_cur),
    .rate_pend(rate_pend)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: mode 0 = stopped, 1 = running, 2 = single step armed.
  // m_age counts edges elapsed in the current period; a period ends when it
  // reaches the divisor of the rate in effect.
  int         mdiv [4] = '{4, 6, 2, 1};
  int         m_mode   = 0;
  int         m_age    = 0;
  bit         m_bnd    = 1'b0;
  logic       m_tick   = 1'b0;
  logic       m_running = 1'b0;
  logic [1:0] m_rate   = 2'd0;
  logic       m_pend   = 1'b0;
  logic [1:0] m_pval   = 2'd0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_tick = 1'b0; m_running = 1'b0;
      m_rate = 2'd0; m_pend = 1'b0; m_pval = 2'd0;
    end else begin
      m_tick = 1'b0;
      case (m_mode)
        0: begin
          if (rate_load) m_rate = rate_sel;
          if (run) begin
            m_mode = 1;
            m_age  = 0;
          end else if (step) begin
            m_mode = 2;
          end
        end
        2: begin
          m_tick = 1'b1;
          m_mode = 0;
          if (rate_load) m_rate = rate_sel;
        end
        default: begin
          if (!run) begin
            m_mode = 0;
            if (rate_load)   m_rate = rate_sel;
            else if (m_pend) m_rate = m_pval;
            m_pend = 1'b0;
          end else begin
            m_age = m_age + 1;
            m_bnd = (m_age == mdiv[m_rate]);
            if (m_bnd) begin
              m_tick = 1'b1;
              m_age  = 0;
            end
            if (rate_load) begin
              m_pend = 1'b1;
              m_pval = rate_sel;
            end else if (m_bnd && m_pend) begin
              m_rate = m_pval;
              m_pend = 1'b0;
            end
          end
        end
      endcase
      m_running = (m_mode == 1);
    end
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic cyc();
    @(negedge clk_in);
    check("m_tick", tick, m_tick);
    check("m_running", running, m_running);
    check("m_rate_cur", rate_cur, m_rate);
    check("m_rate_pend", rate_pend, m_pend);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_tick", tick, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_rate_cur", rate_cur, 2'd0);
    check("rst_rate_pend", rate_pend, 1'b0);

    // First-tick timing at divisor 4: ticks after edges k+4, k+8, k+12
    rst_n = 1'b1;
    run   = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      check("t1_tick", tick, (j == 5 || j == 9 || j == 13));
      check("t1_running", running, 1'b1);
    end

    // Rate change queued mid-period (cnt=1), applied at the terminal count
    rate_sel  = 2'd1;
    rate_load = 1'b1;
    cyc();
    rate_load = 1'b0;
    check("t2_pend_set", rate_pend, 1'b1);
    check("t2_no_tick0", tick, 1'b0);
    cyc();
    check("t2_no_tick1", tick, 1'b0);
    cyc();
    check("t2_bnd_tick", tick, 1'b1);
    check("t2_bnd_rate", rate_cur, 2'd1);
    check("t2_bnd_pend", rate_pend, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      check("t2_div6_tick", tick, (j == 6));
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) run = ~run;
      step      = ($urandom_range(0, 3) == 0);
      rate_load = ($urandom_range(0, 5) == 0);
      rate_sel  = 2'($urandom_range(0, 3));
      cyc();
    end

    // Single step from IDLE
    run = 1'b0; step = 1'b0; rate_load = 1'b0;
    repeat (3) cyc();
    rate_sel  = 2'd0;
    rate_load = 1'b1;
    cyc();
    rate_load = 1'b0;
    check("t3_idle_rate", rate_cur, 2'd0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("t3_step_lat1", tick, 1'b0);
    cyc();
    check("t3_step_tick", tick, 1'b1);
    for (int j = 1; j <= 20; j++) begin
      cyc();
      check("t3_idle_quiet", tick, 1'b0);
    end

    // Step while running is ignored
    run = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step = (j == 3);
      cyc();
      check("t3_run_step_tick", tick, (j == 5 || j == 9));
    end
    step = 1'b0;

    // Drop run at cnt=2, then restart from zero
    for (int j = 10; j <= 11; j++) begin
      cyc();
      check("t4_pre_drop", tick, 1'b0);
    end
    run = 1'b0;
    cyc();
    check("t4_drop_tick", tick, 1'b0);
    check("t4_drop_running", running, 1'b0);
    run = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      cyc();
      check("t4_restart_tick", tick, (j == 5));
      check("t4_restart_running", running, 1'b1);
    end

    // Divisor 1: continuous tick; then switch to divisor 2
    run = 1'b0;
    cyc();
    rate_sel  = 2'd3;
    rate_load = 1'b1;
    cyc();
    rate_load = 1'b0;
    check("t5_rate3", rate_cur, 2'd3);
    run = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      cyc();
      check("t5_div1_tick", tick, (j >= 2));
    end
    rate_sel  = 2'd2;
    rate_load = 1'b1;
    cyc();
    rate_load = 1'b0;
    check("t5_load_tick", tick, 1'b1);
    check("t5_load_pend", rate_pend, 1'b1);
    check("t5_load_rate", rate_cur, 2'd3);
    cyc();
    check("t5_apply_tick", tick, 1'b1);
    check("t5_apply_rate", rate_cur, 2'd2);
    check("t5_apply_pend", rate_pend, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      check("t5_div2_tick", tick, (j % 2 == 0));
    end

    // Asynchronous reset mid-RUN with a pending rate
    rate_sel  = 2'd1;
    rate_load = 1'b1;
    cyc();
    rate_load = 1'b0;
    check("t6_pend", rate_pend, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_tick", tick, 1'b0);
    check("t6_async_running", running, 1'b0);
    check("t6_async_rate_cur", rate_cur, 2'd0);
    check("t6_async_rate_pend", rate_pend, 1'b0);
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      cyc();
      check("t6_post_rst_tick", tick, (j == 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_ctrl.md
Name: tick_ctrl

Overview:
- Run/pause/single-step controller for the board's timebase.
- Owns the divide counter and selects one of four divide ratios.
- Issues a one-cycle clock-enable pulse, tick, to downstream logic; nothing downstream uses a divided clock.
- Rate changes are queued and applied only at period boundaries, so no period is ever truncated.

Parameters:
- DIV0, 25000000, divide ratio for rate_sel=0 (1 Hz tick at 25 MHz equivalent; 2 Hz at 50 MHz)
- DIV1, 12500000, divide ratio for rate_sel=1
- DIV2, 5000000, divide ratio for rate_sel=2
- DIV3, 1, divide ratio for rate_sel=3 (tick every cycle)
- CW, 25, counter width; must satisfy 2^CW >= max(DIVn)

Ports:
- clk_in  in  1  system clock (50 MHz)
- rst_n  in  1  reset; asynchronous assert, active-low
- run  in  1  level; 1 = free-run, 0 = stopped
- step  in  1  one-cycle pulse; request a single tick while stopped
- rate_sel  in  2  divide-ratio index
- rate_load  in  1  one-cycle pulse; latch rate_sel
- tick  out  1  one-cycle enable pulse, registered
- running  out  1  1 while in RUN state, registered
- rate_cur  out  2  index of divisor currently in effect
- rate_pend  out  1  1 while a queued rate change awaits a boundary

Behaviour:
- Reset, async on rst_n low: state=IDLE, cnt=0, tick=0, running=0, rate_cur=0, rate_pend=0, pending index=0. All outputs hold these values while rst_n is low.
- div_cur = DIV[rate_cur]. cnt is CW bits and counts 0..div_cur-1.
- States:
  - IDLE: cnt held at 0, tick=0.
    - run=1 -> RUN.
    - Otherwise step=1 -> STEP.
  - RUN: running=1.
    - Each edge: if cnt==div_cur-1 then cnt<=0 and tick<=1; else cnt<=cnt+1 and tick<=0.
    - run=0 -> IDLE; cnt<=0 and tick<=0 on that same edge.
  - STEP: tick<=1 for exactly one cycle, then -> IDLE.
    - Latency: tick is high in the 2nd cycle after the cycle in which step was sampled.
    - step pulses arriving while in STEP are ignored.
- First-tick timing: when run is first sampled 1 at edge k, the first tick is high during the cycle following edge k+div_cur. After that, tick repeats with period exactly div_cur cycles.
- Divisor of 1: tick stays high continuously in RUN, from the cycle following edge k+1.
- step while in RUN is ignored. If run and step are both 1 in IDLE, run wins.
- Rate load:
  - In IDLE or STEP: rate_cur<=rate_sel on the next edge; rate_pend stays 0.
  - In RUN: the pending index <= rate_sel and rate_pend<=1.
    - At the next edge where cnt==div_cur-1 (the tick-generating edge), rate_cur<=pending and rate_pend<=0. The following period uses the new divisor.
    - rate_load and the terminal count on the same edge: the load goes to pending and applies at the next terminal count, not the current one.
  - A rate_load while rate_pend=1 overwrites the pending index; only the latest value applies.
  - A rate_load selecting the value already in rate_cur still sets rate_pend; it clears at the boundary and the tick cadence is unchanged.
- Leaving RUN (run=0) with rate_pend=1: the pending value is applied on the exit edge and rate_pend<=0.
- run toggling 1->0->1: the counter restarts at 0 and the first-tick timing applies again.
- Reset mid-period: all state is cleared immediately and no partial tick is emitted.

Test Plan:
- Override DIV0=4, DIV1=6, DIV2=2, DIV3=1. After reset, check tick=0, running=0, rate_cur=0, rate_pend=0. Raise run at edge k -> tick high in the cycles after edges k+4, k+8, k+12; running=1 from the cycle after edge k.
- RUN at rate 0, pulse rate_load with rate_sel=1 mid-period (cnt=1) -> rate_pend=1. At the next terminal count: tick fires, rate_cur=1, rate_pend=0. Subsequent ticks are 6 cycles apart; the old period is not shortened.
- IDLE, pulse step -> exactly one tick 2 cycles later. Hold run=0 for 20 cycles -> no further ticks. Pulse step while RUN -> no extra tick and the period is unaffected.
- RUN at DIV0=4, drop run when cnt=2 -> no tick, running=0, cnt=0. Raise run again -> first tick 4 cycles after the sampling edge.
- rate_sel=3 loaded in IDLE, then run=1 -> tick high every cycle. Load rate_sel=2 -> applied at the next edge (every edge is terminal); ticks then alternate 1,0.
- Assert rst_n low asynchronously mid-RUN with rate_pend=1 -> all outputs go to reset values without waiting for a clock edge. After release, tick stays 0 until run is sampled.
